// File: rtl/prf_pkg.sv
// Shared sizes and entry/write types for the physical register file.
package prf_pkg;
    localparam int N                = 3;
    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int DATA_W           = 32;
    localparam int PRN_W            = $clog2(PHYS_REG_SZ_R10K);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PRN_W-1:0]  prn_t;

    typedef struct packed {
        logic  valid;
        data_t value;
    } prf_entry_t;

    typedef struct packed {
        data_t value;
        prn_t  prn;
    } prf_write_t;

    localparam prf_entry_t ENTRY_ZERO = '{valid: 1'b1, value: '0};
endpackage

// File: rtl/prf_if.sv
// Read, writeback and invalidate ports of the register file.
interface prf_if;
    import prf_pkg::*;

    // No handshake: the file is always ready, reads are combinational and
    // writes/invalidates take effect at the next rising clock edge.
    prn_t       [2*N-1:0] read_prn;
    prf_entry_t [2*N-1:0] output_value;
    prf_write_t [N-1:0]   write_data;
    prn_t       [N-1:0]   prn_invalid;

    modport master (
        output read_prn, write_data, prn_invalid,
        input  output_value
    );

    modport slave (
        input  read_prn, write_data, prn_invalid,
        output output_value
    );
endinterface

// File: rtl/prf_popcount.sv
// Population count over a bit vector.
module prf_popcount #(
    parameter  int W  = 63,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end
endmodule

// File: rtl/prf.sv
// Physical register file: PRN 0 hardwired zero, write-bypassed reads,
// write beats invalidate, highest write port wins, registered valid count.
module prf
    import prf_pkg::*;
(
    input  logic                                  clock,
    input  logic                                  reset,
    prf_if.slave                                  bus,
    output prf_entry_t [PHYS_REG_SZ_R10K-1:0]     entries_out,
    output prn_t                                  counter
);
    prf_entry_t [PHYS_REG_SZ_R10K-1:0] entries_q, entries_d;
    prn_t                              counter_q, counter_d;
    logic [PHYS_REG_SZ_R10K-2:0]       valid_vec;

    // Invalidates applied first so a same-edge write to that PRN survives.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < N; i++) begin
            if (bus.prn_invalid[i] != '0) begin
                entries_d[bus.prn_invalid[i]].valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.write_data[i].prn != '0) begin
                entries_d[bus.write_data[i].prn] = '{valid: 1'b1, value: bus.write_data[i].value};
            end
        end
        entries_d[0] = ENTRY_ZERO;
    end

    always_comb begin
        valid_vec = '0;
        for (int k = 1; k < PHYS_REG_SZ_R10K; k++) begin
            valid_vec[k-1] = entries_d[k].valid;
        end
    end

    prf_popcount #(.W(PHYS_REG_SZ_R10K - 1)) u_popcount (
        .bits  (valid_vec),
        .count (counter_d)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            entries_q    <= '0;
            entries_q[0] <= ENTRY_ZERO;
            counter_q    <= '0;
        end else begin
            entries_q    <= entries_d;
            counter_q    <= counter_d;
        end
    end

    // Reads see this cycle's writes; invalidates only show after the edge.
    always_comb begin
        bus.output_value = '0;
        for (int j = 0; j < 2*N; j++) begin
            bus.output_value[j] = entries_q[bus.read_prn[j]];
            for (int i = 0; i < N; i++) begin
                if ((bus.write_data[i].prn != '0) && (bus.write_data[i].prn == bus.read_prn[j])) begin
                    bus.output_value[j] = '{valid: 1'b1, value: bus.write_data[i].value};
                end
            end
        end
    end

    assign entries_out = entries_q;
    assign counter     = counter_q;
endmodule

// File: tb/tb_prf.sv
// Directed bench for prf with a reference model and expected-value queue.
module tb_prf;
    import prf_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    prf_if bus ();
    prf_entry_t [PHYS_REG_SZ_R10K-1:0] entries_out;
    prn_t                              counter;

    prf dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .entries_out (entries_out),
        .counter     (counter)
    );

    int          tests_run = 0;
    int          failures  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] model [PHYS_REG_SZ_R10K];

    function automatic int model_count();
        int c = 0;
        for (int k = 1; k < PHYS_REG_SZ_R10K; k++) c += int'(model[k][32]);
        return c;
    endfunction

    task automatic cmp(input string tag, input logic [32:0] obs);
        logic [32:0] exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        exp_q.push_back(exp);
        cmp(tag, obs);
    endtask

    task automatic clear_inputs();
        bus.read_prn    = '0;
        bus.write_data  = '0;
        bus.prn_invalid = '0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            for (int k = 0; k < PHYS_REG_SZ_R10K; k++) model[k] = '0;
            model[0] = {1'b1, 32'h0};
        end else begin
            for (int i = 0; i < N; i++)
                if (bus.prn_invalid[i] != '0) model[bus.prn_invalid[i]][32] = 1'b0;
            for (int i = 0; i < N; i++)
                if (bus.write_data[i].prn != '0)
                    model[bus.write_data[i].prn] = {1'b1, bus.write_data[i].value};
        end
    endtask

    // Predict post-edge state, clock once, then compare every entry and the count.
    task automatic cycle(input string tag);
        model_edge();
        for (int k = 0; k < PHYS_REG_SZ_R10K; k++) exp_q.push_back(model[k]);
        exp_q.push_back(33'(model_count()));
        @(posedge clock);
        #1;
        for (int k = 0; k < PHYS_REG_SZ_R10K; k++)
            cmp($sformatf("%s entry%0d", tag, k), entries_out[k]);
        cmp($sformatf("%s counter", tag), 33'(counter));
    endtask

    task automatic check_reads(input string tag);
        logic [32:0] e;
        #2;
        for (int j = 0; j < 2*N; j++) begin
            e = model[bus.read_prn[j]];
            for (int i = 0; i < N; i++)
                if (bus.write_data[i].prn != '0 && bus.write_data[i].prn == bus.read_prn[j])
                    e = {1'b1, bus.write_data[i].value};
            exp_q.push_back(e);
        end
        for (int j = 0; j < 2*N; j++)
            cmp($sformatf("%s read%0d prn%0d", tag, j, bus.read_prn[j]), bus.output_value[j]);
    endtask

    initial begin
        logic [31:0] d0, d1, d2;
        int          p;

        clear_inputs();
        reset = 1'b0;
        for (int k = 0; k < PHYS_REG_SZ_R10K; k++) model[k] = '0;

        // Reset held for two edges, then released.
        cycle("reset0");
        cycle("reset1");
        reset = 1'b1;
        bus.read_prn[0] = 6'd5;
        #2;
        expect_val("reset read5 valid", 33'(bus.output_value[0].valid), 33'd0);
        expect_val("reset entry0", entries_out[0], {1'b1, 32'h0});

        // Fill all PRNs in groups of N.
        for (int g = 0; g < 22; g++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) begin
                p = 3*g + i;
                bus.write_data[i].prn   = (p < PHYS_REG_SZ_R10K) ? prn_t'(p) : '0;
                bus.write_data[i].value = $urandom;
            end
            cycle($sformatf("fill%0d", g));
        end
        clear_inputs();
        expect_val("fill counter", 33'(counter), 33'd63);

        // Random invalidates, including PRN 0 and repeated PRNs.
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c == 0) begin
                bus.prn_invalid[0] = 6'd0;
                bus.prn_invalid[1] = 6'd9;
                bus.prn_invalid[2] = 6'd9;
            end else begin
                for (int i = 0; i < N; i++) bus.prn_invalid[i] = prn_t'($urandom_range(0, 63));
            end
            cycle($sformatf("inv%0d", c));
        end
        clear_inputs();
        expect_val("inv entry0", entries_out[0], {1'b1, 32'h0});
        expect_val("inv entry9 valid", 33'(entries_out[9].valid), 33'd0);

        // Random combinational reads.
        for (int j = 0; j < 2*N; j++) bus.read_prn[j] = prn_t'($urandom_range(0, 63));
        check_reads("rand");

        // Bypass: invalidate 4, then write 0..2 while reading 2..7.
        clear_inputs();
        bus.prn_invalid[0] = 6'd4;
        cycle("inv4");
        clear_inputs();
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        bus.write_data[0] = '{value: d0, prn: 6'd0};
        bus.write_data[1] = '{value: d1, prn: 6'd1};
        bus.write_data[2] = '{value: d2, prn: 6'd2};
        for (int j = 0; j < 2*N; j++) bus.read_prn[j] = prn_t'(2 + j);
        check_reads("bypass");
        expect_val("bypass prn2", bus.output_value[0], {1'b1, d2});
        expect_val("bypass prn4 valid", 33'(bus.output_value[2].valid), 33'd0);
        cycle("bypass_edge");

        // Write beats invalidate on the same PRN.
        clear_inputs();
        bus.write_data[0]  = '{value: 32'h1234, prn: 6'd4};
        bus.prn_invalid[0] = 6'd4;
        cycle("wr_vs_inv");
        expect_val("wr_vs_inv prn4", entries_out[4], {1'b1, 32'h1234});

        // Highest write port wins on a shared PRN, both bypassed and stored.
        clear_inputs();
        bus.write_data[0] = '{value: 32'haaaa_0001, prn: 6'd10};
        bus.write_data[2] = '{value: 32'hbbbb_0002, prn: 6'd10};
        bus.read_prn[0]   = 6'd10;
        check_reads("prio");
        expect_val("prio bypass", bus.output_value[0], {1'b1, 32'hbbbb_0002});
        cycle("prio_edge");
        expect_val("prio stored", entries_out[10], {1'b1, 32'hbbbb_0002});

        // Reset overrides a same-edge write.
        clear_inputs();
        bus.write_data[0] = '{value: 32'hdead_beef, prn: 6'd7};
        reset = 1'b0;
        cycle("reset_mid");
        expect_val("reset_mid prn7 valid", 33'(entries_out[7].valid), 33'd0);
        expect_val("reset_mid counter", 33'(counter), 33'd0);
        reset = 1'b1;
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/prf.md
Name: prf

Overview:
- Physical register file of an R10K-style out-of-order core. Holds `PHYS_REG_SZ_R10K` entries, each with a value and a valid (ready) bit.
- Provides 2N combinational read ports (two source operands per dispatched instruction), N write ports (writeback/CDB) and N invalidate ports (newly allocated destination PRNs).
- PRN 0 is a hardwired zero register.
- Exports full entry state and a count of valid entries for debug and verification.

Parameters:
- N, 3, superscalar width (shared define `N`).
- PHYS_REG_SZ_R10K, 64, number of physical registers (shared define).
- DATA width, 32, register value width.
- PRN width, $clog2(PHYS_REG_SZ_R10K), physical register number width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- read_prn  in  2N x PRN  read addresses.
- output_value  out  2N x PRF_ENTRY  read data {valid, value}.
- write_data  in  N x PRF_WRITE  {value, prn}; prn==0 means no write.
- prn_invalid  in  N x PRN  entries to mark not-ready; 0 means no-op.
- entries_out  out  PHYS_REG_SZ_R10K x PRF_ENTRY  registered state of every entry.
- counter  out  PRN  registered number of valid entries among PRN 1..SZ-1.

Behaviour:
- Reset (reset==0 at a rising edge):
  - entry 0 = {valid 1, value 0}.
  - entries 1..SZ-1 = {valid 0, value 0}.
  - counter = 0.
  - Reset overrides any writes or invalidates in the same cycle.
- Entry 0:
  - Always reads {1, 0}.
  - Writes and invalidates targeting PRN 0 are ignored.
  - Entry 0 is never counted.
- Write: for each port i with write_data[i].prn != 0, at the rising edge entry[prn] <= {valid 1, value write_data[i].value}.
- Invalidate: for each port i with prn_invalid[i] != 0, at the rising edge entry[prn].valid <= 0. The value is retained but is don't-care.
- Same-edge priority: a write to a PRN beats an invalidate of the same PRN (result is valid with the new value).
- Same-PRN multiple writes in one cycle: the highest-index write port wins.
- Read (combinational, zero latency): output_value[i] = entry[read_prn[i]] with write bypass.
  - If any write port in the current cycle targets read_prn[i] (≠0), the output is {1, that port's value}, highest port winning.
  - Invalidates are not bypassed; they become visible after the edge.
- entries_out: direct register state, no bypass.
- counter:
  - Registered popcount of the valid bits of entries 1..SZ-1 after the edge's updates.
  - Maximum SZ-1, which fits in PRN width.
  - Re-writing an already-valid entry or invalidating an already-invalid entry leaves the count unchanged.
- Inputs are held stable by the driver; no handshakes, always ready.

Decomposition:
- Shared package/defs (sys_defs): `N`, `PHYS_REG_SZ_R10K`, DATA, PRN, PRF_ENTRY {logic valid; DATA value}, PRF_WRITE {DATA value; PRN prn}.
- One natural sub-module: prf_popcount (parameterized population count over the valid vector, feeds the counter register).
- Read bypass muxes and the next-state logic stay in prf.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → entries_out[0]={1,0}, all other valid=0, counter=0, output_value for read_prn=5 is valid=0.
- Fill: each cycle write N consecutive PRNs (0..63 in groups of 3) with random data → after each edge entries_out matches the written data, PRN 0 stays {1,0}; final counter=63.
- Invalidate: after fill, 10 cycles of N random PRNs on prn_invalid (including 0 and repeats) → valid bits cleared, PRN 0 still valid; counter decrements only for previously valid PRNs.
- Read: after fill, 2N random read_prn → output_value equals stored {1, value} within the same cycle (check 1/5 period after input change).
- Bypass and priority:
  - Invalidate PRN 4, then in one cycle write PRNs 0..2 with new data and read PRNs 2..7 → output for PRN 2 is {1, new data} before the edge.
  - PRN 4 reads valid=0.
  - Write 0x1234 to PRN 4 while prn_invalid=4 → after the edge PRN 4 is {1, 0x1234}.
- Reset mid-operation: assert reset=0 while writing PRN 7 → after the edge PRN 7 valid=0 and counter=0.
